// File: rtl/or_fold_pkg.sv
// Shared types and helpers for the or_fold arbiter slice.
package or_fold_pkg;

    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        RESP    = 2'd2
    } state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/or_fold.sv
// Combinational fold: ORs the upper half of a word onto its lower half.
module or_fold
    import or_fold_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0]   data,
    output logic [DATA_W/2-1:0] result
);

    assign result = data[DATA_W-1:DATA_W/2] | data[DATA_W/2-1:0];

endmodule

// File: rtl/or_fold_arbiter.sv
// Round-robin sharing of one or_fold unit among NUM_REQ requesters.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | waiting for any request; grant is offered combinationally
//  COMPUTE | captured word is folded into the response registers
//  RESP    | response presented until the consumer takes it
module or_fold_arbiter
    import or_fold_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = DEFAULT_DATA_W,
    parameter  int COUNT_W = 16,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic [ID_W-1:0]                  resp_id,
    output logic [DATA_W/2-1:0]              resp_result,
    output logic [COUNT_W-1:0]               served_cnt
);

    if ((DATA_W % 2) != 0 || NUM_REQ < 2) begin : g_param_check
        $error("or_fold_arbiter: DATA_W must be even and NUM_REQ must be at least 2");
    end

    state_t                r_state;
    state_t                w_next_state;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [DATA_W-1:0]     r_data_q;
    logic [ID_W-1:0]       r_id_q;
    logic [ID_W-1:0]       r_resp_id;
    logic [DATA_W/2-1:0]   r_resp_result;
    logic [COUNT_W-1:0]    r_served_cnt;
    logic [ID_W-1:0]       w_grant;
    logic                  w_grant_vld;
    logic [ID_W-1:0]       w_ptr_next;
    logic [DATA_W/2-1:0]   w_fold;

    or_fold #(.DATA_W(DATA_W)) u_or_fold (
        .data   (r_data_q),
        .result (w_fold)
    );

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin : p_grant
        int idx;
        idx         = 0;
        w_grant     = '0;
        w_grant_vld = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!w_grant_vld && req_valid[idx]) begin
                w_grant     = ID_W'(idx);
                w_grant_vld = 1'b1;
            end
        end
        w_ptr_next = (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
        req_ready  = '0;
        if (r_state == IDLE && w_grant_vld) req_ready[w_grant] = 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // FSM next-state and response-valid decode.
    always_comb begin
        w_next_state = r_state;
        resp_valid   = 1'b0;
        case (r_state)
            IDLE:    if (w_grant_vld) w_next_state = COMPUTE;
            COMPUTE: w_next_state = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Capture the granted request, load the folded response, count completions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr      <= '0;
            r_data_q      <= '0;
            r_id_q        <= '0;
            r_resp_id     <= '0;
            r_resp_result <= '0;
            r_served_cnt  <= '0;
        end else begin
            if (r_state == IDLE && w_grant_vld) begin
                r_data_q <= req_data[w_grant];
                r_id_q   <= w_grant;
                r_rr_ptr <= w_ptr_next;
            end
            if (r_state == COMPUTE) begin
                r_resp_result <= w_fold;
                r_resp_id     <= r_id_q;
            end
            if (r_state == RESP && resp_ready) begin
                r_served_cnt <= r_served_cnt + COUNT_W'(1);
            end
        end
    end

    assign resp_id     = r_resp_id;
    assign resp_result = r_resp_result;
    assign served_cnt  = r_served_cnt;

endmodule

// File: tb/tb_or_fold_arbiter.sv
// Self-checking bench for or_fold_arbiter (4 requesters, 16-bit words, 4-bit counter).
module tb_or_fold_arbiter;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req_valid;
    logic [3:0][15:0] req_data;
    logic [3:0]       req_ready;
    logic             resp_valid;
    logic             resp_ready;
    logic [1:0]       resp_id;
    logic [7:0]       resp_result;
    logic [3:0]       served_cnt;

    or_fold_arbiter #(.NUM_REQ(4), .DATA_W(16), .COUNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .served_cnt  (served_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pending words per requester; the head is presented until it is accepted.
    logic [15:0] rq [4][$];

    // Reference model: rr pointer, phase (0 idle, 1 folding, 2 responding), count.
    int          m_ptr;
    int          m_phase;
    int          m_cnt;
    int          m_id;
    logic [7:0]  m_res;

    int          obs_id [$];
    logic [7:0]  obs_res [$];

    typedef struct {
        int          id;
        logic [15:0] data;
        logic [7:0]  exp_res;
        logic [3:0]  exp_ready;
    } vec_t;

    vec_t        tbl [6];
    logic [7:0]  exp2 [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_fold(input logic [15:0] d);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = d[b] | d[b + 8];
        return r;
    endfunction

    // Valid requester with the smallest forward distance from the pointer.
    function automatic int ref_pick();
        int best = -1;
        int bd   = 99;
        for (int i = 0; i < 4; i++) begin
            int d;
            d = (i - m_ptr + 4) % 4;
            if (rq[i].size() > 0 && d < bd) begin
                bd   = d;
                best = i;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_phase = 0;
        m_cnt   = 0;
        m_id    = 0;
        m_res   = 8'h00;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = (rq[i].size() > 0);
            req_data[i]  = (rq[i].size() > 0) ? rq[i][0] : 16'h0000;
        end
    endtask

    // One clock: drive at the falling edge, check against the model, advance both.
    task automatic cycle(input bit rdy);
        int         g;
        logic [3:0] er;
        resp_ready = rdy;
        drive_inputs();
        #1;
        g  = ref_pick();
        er = 4'b0000;
        if (m_phase == 0 && g >= 0) er[g] = 1'b1;
        chk("req_ready", req_ready, er);
        chk("resp_valid", resp_valid, (m_phase == 2));
        if (m_phase == 2) begin
            chk("resp_id", resp_id, m_id);
            chk("resp_result", resp_result, m_res);
        end
        chk("served_cnt", served_cnt, m_cnt % 16);
        if (resp_valid && rdy) begin
            obs_id.push_back(int'(resp_id));
            obs_res.push_back(resp_result);
        end
        case (m_phase)
            0: if (g >= 0) begin
                m_id    = g;
                m_res   = ref_fold(rq[g][0]);
                void'(rq[g].pop_front());
                m_ptr   = (g + 1) % 4;
                m_phase = 1;
            end
            1: m_phase = 2;
            default: if (rdy) begin
                m_cnt++;
                m_phase = 0;
            end
        endcase
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{0, 16'hA50F, 8'hAF, 4'b0001};
        tbl[1] = '{1, 16'hFF00, 8'hFF, 4'b0010};
        tbl[2] = '{2, 16'h1234, 8'h36, 4'b0100};
        tbl[3] = '{0, 16'h8001, 8'h81, 4'b0001};
        tbl[4] = '{2, 16'h0000, 8'h00, 4'b0100};
        tbl[5] = '{3, 16'h0F0F, 8'h0F, 4'b1000};
        exp2   = '{8'h03, 8'h07, 8'h0D, 8'h30};

        rst_n      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        resp_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_result", resp_result, 0);
        chk("rst_served_cnt", served_cnt, 0);
        chk("rst_req_ready", req_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-requester vectors: grant, two-edge latency, fold result, count.
        for (int i = 0; i < 6; i++) begin
            rq[tbl[i].id].push_back(tbl[i].data);
            resp_ready = 1'b1;
            drive_inputs();
            #1;
            chk("tbl_ready", req_ready, tbl[i].exp_ready);
            cycle(1);
            cycle(1);
            chk("tbl_resp_valid", resp_valid, 1);
            chk("tbl_resp_id", resp_id, tbl[i].id);
            chk("tbl_resp_result", resp_result, tbl[i].exp_res);
            cycle(1);
            chk("tbl_cnt", served_cnt, i + 1);
        end

        // All four valid together, pointer at 0: served 0,1,2,3.
        obs_id.delete();
        obs_res.delete();
        rq[0].push_back(16'h0102);
        rq[1].push_back(16'h0304);
        rq[2].push_back(16'h0508);
        rq[3].push_back(16'h1020);
        repeat (14) cycle(1);
        chk("all4_count", obs_id.size(), 4);
        for (int k = 0; k < 4 && k < obs_id.size(); k++) begin
            chk("all4_id", obs_id[k], k);
            chk("all4_result", obs_res[k], exp2[k]);
        end

        // Two requesters held valid alternate 0,2,0,2,0,2.
        obs_id.delete();
        obs_res.delete();
        for (int k = 0; k < 3; k++) begin
            rq[0].push_back(16'($urandom()));
            rq[2].push_back(16'($urandom()));
        end
        repeat (20) cycle(1);
        chk("alt_count", obs_id.size(), 6);
        for (int k = 0; k < 6 && k < obs_id.size(); k++) begin
            chk("alt_id", obs_id[k], (k % 2 == 1) ? 2 : 0);
        end

        // Response stall: five cycles of resp_ready=0, a new request rises meanwhile.
        rq[2].push_back(16'hC3A5);
        cycle(1);
        cycle(0);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) rq[0].push_back(16'h5A00);
            cycle(0);
        end
        chk("stall_id", resp_id, 2);
        chk("stall_result", resp_result, 8'hE7);
        chk("stall_ready", req_ready, 0);
        cycle(1);
        repeat (5) cycle(1);

        // Reset while req1 is folding: dropped, then re-accepted after release.
        obs_id.delete();
        obs_res.delete();
        rq[1].push_back(16'hFF00);
        cycle(1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_resp_valid", resp_valid, 0);
        chk("rst_mid_cnt", served_cnt, 0);
        model_reset();
        rq[1].push_front(16'hFF00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) cycle(1);
        chk("rst_mid_count", obs_id.size(), 1);
        if (obs_id.size() > 0) begin
            chk("rst_mid_id", obs_id[0], 1);
            chk("rst_mid_result", obs_res[0], 8'hFF);
        end

        // Counter wrap: 17 back-to-back operations from req3 after a fresh reset.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 17; k++) rq[3].push_back(16'($urandom()));
        for (int c = 0; c < 80 && m_cnt < 17; c++) begin
            int prev;
            prev = m_cnt;
            cycle(1);
            if (m_cnt != prev) begin
                if (m_cnt == 15) chk("wrap_15", served_cnt, 15);
                if (m_cnt == 16) chk("wrap_16", served_cnt, 0);
                if (m_cnt == 17) chk("wrap_17", served_cnt, 1);
            end
        end
        chk("wrap_final", served_cnt, 1);

        // Random traffic against the model.
        repeat (400) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0 && rq[i].size() < 3)
                    rq[i].push_back(16'($urandom()));
            end
            cycle($urandom_range(0, 3) != 0);
        end
        repeat (60) cycle(1);
        chk("drain_idle", resp_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
